// File: rtl/otter_muldiv_if.sv
// Request/response bundle between the control unit and the multiply/divide unit.
//   start  : request strobe, sampled only while the unit is idle
//   funct3 : RV32M operation select (MUL..REMU)
//   src_a  : rs1 operand / dividend
//   src_b  : rs2 operand / divisor
//   busy   : unit is working; the pipeline stalls on it
//   done   : one-cycle pulse, result valid in that cycle
//   result : last completed result, held until the next done
interface otter_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, src_a, src_b,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, src_a, src_b,
        output busy, done, result
    );
endinterface

// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide unit with a uniform WIDTH+1 cycle latency.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; aborts any operation in flight
//   bus : otter_muldiv_if slave (start/funct3/src_a/src_b in, busy/done/result out)
// Operands are reduced to magnitudes at acceptance. WIDTH radix-2 steps then run
// on a shared 2*WIDTH accumulator:
//   multiply : {partial product, multiplier}
//   divide   : {remainder, quotient/dividend}
// Signs are reapplied when the last step completes.
module otter_muldiv #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    otter_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [2:0]         op;
    logic               sign_a, sign_b, div_zero;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH:0]     add_sum, rem_shift;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quot_fin, rem_fin, fin_value;
    logic               in_sa, in_sb;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Which operand is interpreted as two's complement for a given funct3.
    function automatic logic a_is_signed(input logic [2:0] f);
        return !(f == 3'b011 || f == 3'b101 || f == 3'b111);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == 3'b000 || f == 3'b001 || f == 3'b100 || f == 3'b110);
    endfunction

    assign in_sa    = a_is_signed(bus.funct3) & bus.src_a[WIDTH-1];
    assign in_sb    = b_is_signed(bus.funct3) & bus.src_b[WIDTH-1];
    assign in_mag_a = negate_w(bus.src_a, in_sa);
    assign in_mag_b = negate_w(bus.src_b, in_sb);

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == FIN);
    assign bus.result = result_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (count == CNT_W'(1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One radix-2 step. For divide, the trial remainder is always below twice
    // the divisor, so the W-bit difference is exact whenever it is taken.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        if (op[2]) begin
            if (rem_shift >= {1'b0, operand})
                acc_step = {rem_shift[WIDTH-1:0] - operand, acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {add_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the value produced by the final step.
    // A zero divisor yields all-ones for the quotient regardless of sign;
    // the remainder naturally returns the dividend.
    always_comb begin
        prod_fin = negate_2w(acc_step, sign_a ^ sign_b);
        quot_fin = div_zero ? '1 : negate_w(acc_step[WIDTH-1:0], sign_a ^ sign_b);
        rem_fin  = negate_w(acc_step[2*WIDTH-1:WIDTH], sign_a);
        unique case (op)
            3'b000:                 fin_value = prod_fin[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin_value = prod_fin[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin_value = quot_fin;
            default:                fin_value = rem_fin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            op       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    op       <= bus.funct3;
                    sign_a   <= in_sa;
                    sign_b   <= in_sb;
                    div_zero <= (bus.src_b == '0);
                    count    <= CNT_W'(WIDTH);
                    operand  <= bus.funct3[2] ? in_mag_b : in_mag_a;
                    acc      <= {{WIDTH{1'b0}}, (bus.funct3[2] ? in_mag_a : in_mag_b)};
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) result_q <= fin_value;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_otter_muldiv.sv
module tb_otter_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    otter_muldiv_if #(.WIDTH(W)) bus ();
    otter_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference built from the RV32M rules with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one request and wait for DONE, checking latency, result and pulse width.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = f; bus.src_a = a; bus.src_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.src_a = $urandom; bus.src_b = $urandom;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_res"}, 64'(bus.result), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
        check({tag, "_hold"}, 64'(bus.result), 64'(exp));
    endtask

    initial begin
        int          lat, ndone;
        logic        bad;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [31:0] specials [4];

        specials[0] = 32'h0; specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;

        bus.start = 1'b0; bus.funct3 = '0; bus.src_a = '0; bus.src_b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        rst = 1'b0;

        // Directed operations
        do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14);
        do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);
        do_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        do_op("rem0", 3'b110, 32'd5, 32'd0, 32'd5);
        do_op("divneg0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        do_op("divu0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF);
        do_op("remu0", 3'b111, 32'd9, 32'd0, 32'd9);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Operand changes and repeated START while busy must not disturb the operation
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.src_a = 32'd1234; bus.src_b = 32'hFFFF_FFFB;
        @(posedge clk); #1;
        bad = 1'b0; ndone = 0; lat = 1;
        for (int i = 1; i <= 10; i++) begin
            bus.start = 1'b1; bus.funct3 = 3'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
            if (!bus.busy || bus.done) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        while (!bus.done && lat < 40) begin
            if (!bus.busy) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("ignore_busy", 64'(bad), 64'd0);
        check("ignore_lat", 64'(lat), 64'd33);
        check("ignore_res", 64'(bus.result), 64'(model(3'b000, 32'd1234, 32'hFFFF_FFFB)));
        check("ignore_res_const", 64'(bus.result), 64'hFFFF_E7E6);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("ignore_single_done", 64'(ndone), 64'd0);

        // Reset in the middle of a divide
        do_op("pre_rst", 3'b101, 32'd1000, 32'd3, 32'd333);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.src_a = 32'd12345; bus.src_b = 32'd17;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        do_op("post_rst", 3'b100, 32'd12345, 32'd17, 32'd726);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = specials[$urandom_range(0, 3)];
                2:       b = 32'($urandom_range(1, 20));
                default: b = 32'($urandom);
            endcase
            do_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, model(f, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
